// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ID-stage operand forwarding, load-use / RAW / MDU stall generation, IF/ID
// flush on taken branches and a saturating stall-cycle counter for the
// 5-stage MIPS pipeline. Forwarding, stall and flush are combinational so the
// ID stage sees them in the same cycle; MDU state and the counter are registered.
module hazard_fwd_unit #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int FWD_EN  = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_use,
    input  logic          id_rt_use,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic          id_mdu_start,
    input  logic          id_mdu_div,
    input  logic          id_mdu_read,
    input  logic          em_rfwr,
    input  logic          em_mr,
    input  logic [RW-1:0] em_rdst,
    input  logic [DW-1:0] em_alu,
    input  logic          mw_rfwr,
    input  logic          mw_mr,
    input  logic [RW-1:0] mw_rdst,
    input  logic [DW-1:0] mw_alu,
    input  logic [DW-1:0] mw_mem,
    input  logic          br_taken,
    output logic [DW-1:0] fwd_rs,
    output logic [DW-1:0] fwd_rt,
    output logic          stall,
    output logic          flush,
    output logic          mdu_busy,
    output logic [CW-1:0] stall_cnt
);
    // Counter must hold the longer of the two latencies.
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int KW      = $clog2(MAX_LAT + 32'sd1);
    localparam logic [KW-1:0] DIV_LOAD = KW'(DIV_LAT);
    localparam logic [KW-1:0] MUL_LOAD = KW'(MUL_LAT);
    localparam logic [KW-1:0] K_ONE    = KW'(1'b1);
    localparam logic [CW-1:0] C_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] C_MAX    = {CW{1'b1}};

    // A stage produces operand x when it writes the RF, targets a non-zero
    // register equal to x, and the ID instruction really reads x.
    function automatic logic reg_match(input logic wr, input logic [RW-1:0] dst,
                                       input logic [RW-1:0] src, input logic rd_use);
        reg_match = wr && (dst != {RW{1'b0}}) && (dst == src) && rd_use;
    endfunction

    logic          em_rs_s, em_rt_s, mw_rs_s, mw_rt_s;
    logic [DW-1:0] rs_val_s, rt_val_s;
    logic          raw_hz_s, mdu_hz_s, hazard_s, issue_s;
    logic [KW-1:0] cnt_r, cnt_nxt_s;
    logic          mdu_busy_r;
    logic [CW-1:0] stall_cnt_r;

    // Producer matches for both operands against both downstream stages.
    always_comb begin
        em_rs_s = reg_match(em_rfwr, em_rdst, id_rs, id_rs_use);
        em_rt_s = reg_match(em_rfwr, em_rdst, id_rt, id_rt_use);
        mw_rs_s = reg_match(mw_rfwr, mw_rdst, id_rs, id_rs_use);
        mw_rt_s = reg_match(mw_rfwr, mw_rdst, id_rt, id_rt_use);
    end

    // Operand selection: youngest producer wins; a load still in EX/MEM has no data yet.
    always_comb begin
        rs_val_s = id_rd1;
        rt_val_s = id_rd2;
        raw_hz_s = 1'b0;
        if (FWD_EN != 32'sd0) begin
            if (em_rs_s) begin
                if (em_mr) begin
                    raw_hz_s = 1'b1;
                end else begin
                    rs_val_s = em_alu;
                end
            end else if (mw_rs_s) begin
                if (mw_mr) begin
                    rs_val_s = mw_mem;
                end else begin
                    rs_val_s = mw_alu;
                end
            end else begin
                rs_val_s = id_rd1;
            end
            if (em_rt_s) begin
                if (em_mr) begin
                    raw_hz_s = 1'b1;
                end else begin
                    rt_val_s = em_alu;
                end
            end else if (mw_rt_s) begin
                if (mw_mr) begin
                    rt_val_s = mw_mem;
                end else begin
                    rt_val_s = mw_alu;
                end
            end else begin
                rt_val_s = id_rd2;
            end
        end else begin
            raw_hz_s = em_rs_s | em_rt_s | mw_rs_s | mw_rt_s;
        end
    end

    // MDU result pending: hold HI/LO reads and any new issue; a taken branch kills the issue.
    always_comb begin
        mdu_hz_s = (id_mdu_read | id_mdu_start) & (cnt_r != {KW{1'b0}});
        hazard_s = raw_hz_s | mdu_hz_s;
        issue_s  = id_mdu_start & ~hazard_s & ~br_taken;
    end

    // Next MDU busy count: reload on issue, otherwise drain towards zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (issue_s) begin
            cnt_nxt_s = id_mdu_div ? DIV_LOAD : MUL_LOAD;
        end else if (cnt_r != {KW{1'b0}}) begin
            cnt_nxt_s = cnt_r - K_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pipeline control outputs; flush takes precedence over stall, all quiet in reset.
    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        fwd_rs = {DW{1'b0}};
        fwd_rt = {DW{1'b0}};
        if (rst) begin
            stall  = 1'b0;
            flush  = 1'b0;
        end else begin
            stall  = hazard_s & ~br_taken;
            flush  = br_taken;
            fwd_rs = rs_val_s;
            fwd_rt = rt_val_s;
        end
    end

    // MDU counter, busy flag and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {KW{1'b0}};
            mdu_busy_r  <= 1'b0;
            stall_cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r      <= cnt_nxt_s;
            mdu_busy_r <= (cnt_nxt_s != {KW{1'b0}});
            if (stall && (stall_cnt_r != C_MAX)) begin
                stall_cnt_r <= stall_cnt_r + C_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign mdu_busy  = mdu_busy_r;
    assign stall_cnt = stall_cnt_r;

endmodule
